// File: rtl/data_cache_ctrl_pkg.sv
// Shared widths, address layout and controller state encoding
// for the direct-mapped write-through data cache.
package data_cache_ctrl_pkg;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES    = 1 << INDEX_W;
    localparam int WORDS    = 1 << OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_e;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } addr_t;

endpackage

// File: rtl/data_cache_ctrl_data_array.sv
// Tag RAM, valid bits and data RAM: synchronous write,
// asynchronous read, valid bits cleared asynchronously.
module cache_data_array
    import data_cache_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    input  logic [TAG_W-1:0]    rd_tag,
    output logic                rd_hit,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                line_inval,
    input  logic                line_fill,
    input  logic [INDEX_W-1:0]  line_index,
    input  logic [TAG_W-1:0]    line_tag
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_ram [LINES];
    logic [DATA_W-1:0] data_ram [LINES*WORDS];

    always_comb begin
        valid_d = valid_q;
        if (line_inval) valid_d[line_index] = 1'b0;
        if (line_fill)  valid_d[line_index] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (line_fill) tag_ram[line_index] <= line_tag;
        if (wr_en)     data_ram[{wr_index, wr_offset}] <= wr_data;
    end

    assign rd_hit  = valid_q[rd_index] && (tag_ram[rd_index] == rd_tag);
    assign rd_data = data_ram[{rd_index, rd_offset}];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache
// controller: refill/write FSM, beat counter, main-memory port.
module data_cache_ctrl
    import data_cache_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              mm_rd_req,
    output logic              mm_wr_req,
    output logic [ADDR_W-1:0] mm_addr,
    output logic [DATA_W-1:0] mm_wdata,
    input  logic [DATA_W-1:0] mm_rdata,
    input  logic              mm_ready
);

    state_e              state_q, state_d;
    logic [OFFSET_W-1:0] beat_q, beat_d, beat_inc;
    logic                rd_req_q, rd_req_d;
    logic                wr_req_q, wr_req_d;
    logic [ADDR_W-1:0]   mm_addr_q, mm_addr_d;
    logic [DATA_W-1:0]   mm_wdata_q, mm_wdata_d;

    addr_t               a;
    logic [INDEX_W-1:0]  fill_index;
    logic [TAG_W-1:0]    fill_tag;
    logic                hit;
    logic                arr_wr_en;
    logic [INDEX_W-1:0]  arr_wr_index;
    logic [OFFSET_W-1:0] arr_wr_offset;
    logic [DATA_W-1:0]   arr_wr_data;
    logic                line_inval;
    logic                line_fill;
    logic [INDEX_W-1:0]  line_index;

    assign a          = addr_t'(addr);
    assign fill_index = mm_addr_q[OFFSET_W +: INDEX_W];
    assign fill_tag   = mm_addr_q[ADDR_W-1 -: TAG_W];
    assign beat_inc   = beat_q + OFFSET_W'(1);

    cache_data_array u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_index   (a.index),
        .rd_offset  (a.offset),
        .rd_tag     (a.tag),
        .rd_hit     (hit),
        .rd_data    (rdata),
        .wr_en      (arr_wr_en),
        .wr_index   (arr_wr_index),
        .wr_offset  (arr_wr_offset),
        .wr_data    (arr_wr_data),
        .line_inval (line_inval),
        .line_fill  (line_fill),
        .line_index (line_index),
        .line_tag   (fill_tag)
    );

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        rd_req_d      = rd_req_q;
        wr_req_d      = wr_req_q;
        mm_addr_d     = mm_addr_q;
        mm_wdata_d    = mm_wdata_q;
        stall         = 1'b0;
        arr_wr_en     = 1'b0;
        arr_wr_index  = a.index;
        arr_wr_offset = a.offset;
        arr_wr_data   = wdata;
        line_inval    = 1'b0;
        line_fill     = 1'b0;
        line_index    = a.index;
        unique case (state_q)
            ST_IDLE: begin
                // Stores win over loads if both are raised.
                if (mem_write) begin
                    stall      = 1'b1;
                    state_d    = ST_WRITE;
                    wr_req_d   = 1'b1;
                    mm_addr_d  = addr;
                    mm_wdata_d = wdata;
                    arr_wr_en  = hit;
                end else if (mem_read && !hit) begin
                    stall      = 1'b1;
                    state_d    = ST_REFILL;
                    beat_d     = '0;
                    rd_req_d   = 1'b1;
                    mm_addr_d  = {a.tag, a.index, {OFFSET_W{1'b0}}};
                    line_inval = 1'b1;
                end
            end
            ST_REFILL: begin
                stall         = 1'b1;
                line_index    = fill_index;
                arr_wr_index  = fill_index;
                arr_wr_offset = beat_q;
                arr_wr_data   = mm_rdata;
                if (mm_ready) begin
                    arr_wr_en = 1'b1;
                    beat_d    = beat_inc;
                    if (&beat_q) begin
                        rd_req_d  = 1'b0;
                        line_fill = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        mm_addr_d = {mm_addr_q[ADDR_W-1:OFFSET_W], beat_inc};
                    end
                end
            end
            ST_WRITE: begin
                stall = !mm_ready;
                if (mm_ready) begin
                    wr_req_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rd_req_d = 1'b0;
                wr_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            mm_addr_q  <= '0;
            mm_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            rd_req_q   <= rd_req_d;
            wr_req_q   <= wr_req_d;
            mm_addr_q  <= mm_addr_d;
            mm_wdata_q <= mm_wdata_d;
        end
    end

    assign mm_rd_req = rd_req_q;
    assign mm_wr_req = wr_req_q;
    assign mm_addr   = mm_addr_q;
    assign mm_wdata  = mm_wdata_q;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl with a 2-cycle main memory
// that returns 0xA000_0000 + address on reads.
module tb_data_cache_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        mm_rd_req;
    logic        mm_wr_req;
    logic [9:0]  mm_addr;
    logic [31:0] mm_wdata;
    logic [31:0] mm_rdata;
    logic        mm_ready;

    int applied;
    int miscompares;
    int wcnt;

    data_cache_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .mm_rd_req (mm_rd_req),
        .mm_wr_req (mm_wr_req),
        .mm_addr   (mm_addr),
        .mm_wdata  (mm_wdata),
        .mm_rdata  (mm_rdata),
        .mm_ready  (mm_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [9:0]  a;
        logic [31:0] d;
        int          exp_stall;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_beats;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: ready on the second cycle of each request beat.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n && (mm_rd_req || mm_wr_req)) begin
            if (wcnt == 1) begin
                mm_ready = 1'b1;
                wcnt     = 0;
            end else begin
                mm_ready = 1'b0;
                wcnt++;
            end
        end else begin
            mm_ready = 1'b0;
            wcnt     = 0;
        end
        mm_rdata = 32'hA000_0000 + {22'd0, mm_addr};
    endtask

    task automatic do_op(input string tag, input logic rd, input logic wr,
                         input logic [9:0] a, input logic [31:0] d,
                         output int stalls, output int beats,
                         output int wr_seen, output logic [31:0] rd_out);
        logic [9:0] base;
        base      = {a[9:2], 2'b00};
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        stalls    = 0;
        beats     = 0;
        wr_seen   = 0;
        #1;
        while (stall && stalls < 40) begin
            if (mm_rd_req && mm_ready) begin
                check({tag, " beat addr"}, {22'd0, mm_addr},
                      {22'd0, base + 10'(beats)});
                beats++;
            end
            stalls++;
            tick();
            #1;
        end
        if (stalls >= 40)
            check({tag, " timeout"}, 32'(stalls), 32'd0);
        if (mm_wr_req && mm_ready) begin
            wr_seen = 1;
            check({tag, " wr addr"}, {22'd0, mm_addr}, {22'd0, a});
            check({tag, " wr data"}, mm_wdata, d);
        end
        rd_out = rdata;
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        int          st;
        int          bt;
        int          ws;
        int          n;
        logic [31:0] rv;

        applied     = 0;
        miscompares = 0;
        wcnt        = 0;
        rst_n       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        addr        = '0;
        wdata       = '0;
        mm_ready    = 1'b0;
        mm_rdata    = '0;

        vecs[0]  = '{1, 0, 10'h045, 32'h0, 9, 1, 32'hA000_0045, 4};
        vecs[1]  = '{1, 0, 10'h046, 32'h0, 0, 1, 32'hA000_0046, 0};
        vecs[2]  = '{0, 1, 10'h046, 32'h1234_5678, 2, 0, 32'h0, 0};
        vecs[3]  = '{1, 0, 10'h046, 32'h0, 0, 1, 32'h1234_5678, 0};
        vecs[4]  = '{0, 1, 10'h3C6, 32'hCAFE_F00D, 2, 0, 32'h0, 0};
        vecs[5]  = '{1, 0, 10'h045, 32'h0, 0, 1, 32'hA000_0045, 0};
        vecs[6]  = '{1, 0, 10'h3C6, 32'h0, 9, 1, 32'hA000_03C6, 4};
        vecs[7]  = '{1, 0, 10'h045, 32'h0, 9, 1, 32'hA000_0045, 4};
        vecs[8]  = '{1, 0, 10'h047, 32'h0, 0, 1, 32'hA000_0047, 0};
        vecs[9]  = '{1, 1, 10'h010, 32'h55AA_55AA, 2, 0, 32'h0, 0};
        vecs[10] = '{1, 0, 10'h010, 32'h0, 9, 1, 32'hA000_0010, 4};
        vecs[11] = '{1, 0, 10'h3FF, 32'h0, 9, 1, 32'hA000_03FF, 4};
        vecs[12] = '{1, 0, 10'h3FC, 32'h0, 0, 1, 32'hA000_03FC, 0};

        #12;
        check("rst rd_req", {31'd0, mm_rd_req}, 32'd0);
        check("rst wr_req", {31'd0, mm_wr_req}, 32'd0);
        check("rst mm_addr", {22'd0, mm_addr}, 32'd0);
        check("rst mm_wdata", mm_wdata, 32'd0);
        check("rst stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            do_op($sformatf("v%0d", i), vecs[i].rd, vecs[i].wr,
                  vecs[i].a, vecs[i].d, st, bt, ws, rv);
            check($sformatf("v%0d stall cycles", i), 32'(st),
                  32'(vecs[i].exp_stall));
            check($sformatf("v%0d rd beats", i), 32'(bt),
                  32'(vecs[i].exp_beats));
            check($sformatf("v%0d wr done", i), 32'(ws),
                  {31'd0, vecs[i].wr});
            if (vecs[i].chk_rd)
                check($sformatf("v%0d rdata", i), rv, vecs[i].exp_rd);
        end

        // Reset during refill beat 2 of a conflicting miss.
        mem_read = 1'b1;
        addr     = 10'h3C6;
        n        = 0;
        st       = 0;
        #1;
        while (n < 2 && st < 40) begin
            if (mm_rd_req && mm_ready) n++;
            tick();
            #1;
            st++;
        end
        check("mid reset reach beat2", 32'(n), 32'd2);
        check("mid reset req before", {31'd0, mm_rd_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset rd_req", {31'd0, mm_rd_req}, 32'd0);
        check("mid reset mm_addr", {22'd0, mm_addr}, 32'd0);
        mem_read = 1'b0;
        mm_ready = 1'b0;
        wcnt     = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_op("post reset", 1'b1, 1'b0, 10'h045, 32'h0, st, bt, ws, rv);
        check("post reset stall", 32'(st), 32'd9);
        check("post reset beats", 32'(bt), 32'd4);
        check("post reset rdata", rv, 32'hA000_0045);
        do_op("post reset hit", 1'b1, 1'b0, 10'h044, 32'h0, st, bt, ws, rv);
        check("post reset hit stall", 32'(st), 32'd0);
        check("post reset hit rdata", rv, 32'hA000_0044);

        // Idle with no request: memory ready must be ignored.
        mm_ready = 1'b1;
        #1;
        check("idle stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        mm_ready = 1'b0;
        check("idle no req", {30'd0, mm_rd_req, mm_wr_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule
